// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: function codes, code width and
// the flag bundle carried alongside each result.
package alu_pkg;

  localparam int NB_OP = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SLL = 6'b000000;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and flags from already-registered
// operands and function code.
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_DATA = 6
) (
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [NB_OP-1:0]   op_i,
  output logic [NB_DATA-1:0] res_o,
  output alu_flags_t         flags_o
);

  localparam int MSB = NB_DATA - 1;
  localparam logic [NB_DATA-1:0] SH_LIM = NB_DATA'(NB_DATA);

  logic [NB_DATA:0] sum;
  logic [NB_DATA:0] diff;
  logic             shift_big;

  // The extra top bit of diff is the unsigned borrow (A < B).
  assign sum       = {1'b0, a_i} + {1'b0, b_i};
  assign diff      = {1'b0, a_i} - {1'b0, b_i};
  assign shift_big = (b_i >= SH_LIM);

  always_comb begin
    res_o   = '0;
    flags_o = '0;
    case (op_i)
      OP_ADD: begin
        res_o            = sum[MSB:0];
        flags_o.carry    = sum[NB_DATA];
        flags_o.overflow = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        res_o            = diff[MSB:0];
        flags_o.carry    = diff[NB_DATA];
        flags_o.overflow = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_NOR: res_o = ~(a_i | b_i);
      OP_SLL: res_o = shift_big ? '0 : (a_i << b_i);
      OP_SRL: res_o = shift_big ? '0 : (a_i >> b_i);
      OP_SRA: res_o = shift_big ? {NB_DATA{a_i[MSB]}}
                                : NB_DATA'($signed(a_i) >>> b_i);
      default: flags_o.err = 1'b1;
    endcase
    flags_o.zero = (res_o == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 registers operands, S2 registers result and
// flags. Valid/ready on both sides with full backpressure.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int NB_DATA = 6,
  parameter int NB_OP_P = NB_OP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_DATA-1:0] i_A,
  input  logic [NB_DATA-1:0] i_B,
  input  logic [NB_OP_P-1:0] i_OP,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_res,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_err
);

  if (NB_OP_P != 6) begin : g_bad_op_width
    $error("alu_pipe: NB_OP must be 6");
  end
  if (NB_DATA < 4 || NB_DATA > 32) begin : g_bad_data_width
    $error("alu_pipe: NB_DATA must be within 4..32");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A stage advances when it is empty or its downstream advances, so
  // o_ready depends combinationally on i_ready and a full pipe can accept
  // and deliver in the same cycle without a bubble.
  logic               s1_valid_q;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0]   op_q;
  logic               s2_valid_q;
  logic [NB_DATA-1:0] res_q;
  alu_flags_t         flags_q;

  logic [NB_DATA-1:0] res_d;
  alu_flags_t         flags_d;
  logic               s1_adv;
  logic               s2_adv;

  assign s2_adv  = !s2_valid_q || i_ready;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign o_ready = s1_adv;

  alu_core #(.NB_DATA(NB_DATA)) u_core (
    .a_i     (a_q),
    .b_i     (b_q),
    .op_i    (op_q),
    .res_o   (res_d),
    .flags_o (flags_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        a_q  <= i_A;
        b_q  <= i_B;
        op_q <= i_OP[NB_OP-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign o_valid    = s2_valid_q;
  assign o_res      = res_q;
  assign o_zero     = flags_q.zero;
  assign o_carry    = flags_q.carry;
  assign o_overflow = flags_q.overflow;
  assign o_err      = flags_q.err;

endmodule
